lsu_bus_bridge: RTL and testbench
=================================

// Module: lsu_bus_bridge
// PURPOSE
//  Load/store bridge between the multicycle core and a ready/valid memory bus.
//  Generalises the core's single-cycle memory_read/memory_write port with:
//   - wait-state handshake and a bus timeout;
//   - byte/half/word access with byte strobes and lane steering;
//   - load sign/zero extension;
//   - misalignment and illegal-funct3 error reporting.
//  Sits between the core's memory-address/data path and the system memory bus.
// PARAMETERS
//  ADDR_WIDTH      32   core/bus address width (>=3)
//  TIMEOUT_CYCLES  255  max cycles mem_valid is held without mem_ready; 0 = never time out
//  CNT_WIDTH       8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1           clock, all logic on posedge
//  reset        in   1           reset, synchronous, active-high
//  core_req     in   1           start access; sampled only in IDLE
//  core_we      in   1           1 = store, 0 = load
//  core_funct3  in   3           RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  core_addr    in   ADDR_WIDTH  byte address
//  core_wdata   in   32          store data, right-aligned
//  core_rdata   out  32          extended load result; holds until next load completes
//  core_done    out  1           1-cycle pulse: access completed OK
//  core_error   out  1           1-cycle pulse: misaligned, illegal funct3 or timeout
//  core_busy    out  1           high in every state except IDLE
//  mem_valid    out  1           bus request; held high until mem_ready
//  mem_we       out  1           bus write enable
//  mem_addr     out  ADDR_WIDTH  word-aligned address {core_addr[AW-1:2],2'b00}
//  mem_wstrb    out  4           byte strobes; 4'b0000 for loads
//  mem_wdata    out  32          lane-replicated store data
//  mem_ready    in   1           bus accepts/completes access; ignored while mem_valid=0
//  mem_rdata    in   32          read data, valid in the cycle mem_ready=1
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including core_rdata.
//   Reset during REQ drops mem_valid on the next edge; no done/error pulse.
//  States and transitions:
//   IDLE: on core_req=1, latch we/funct3/addr/wdata and decode.
//     Illegal or misaligned -> ERR; otherwise -> REQ.
//     Illegal: load funct3 in {011,110,111}; store funct3[2]=1 or funct3=011.
//     Misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
//   REQ: mem_valid=1; mem_* stable and driven from latched values.
//     mem_ready=1 at an edge -> DONE; capture mem_rdata if load.
//     Timeout counter clears on entry and increments each REQ cycle.
//     Counter == TIMEOUT_CYCLES-1 with mem_ready=0 -> ERR; mem_valid drops.
//     mem_ready and timeout on the same edge: mem_ready wins.
//   DONE: core_done=1 for one cycle -> IDLE.
//   ERR:  core_error=1 for one cycle -> IDLE. No bus access is issued for decode errors.
//  Latency: core_req at edge N -> mem_valid high from N+1.
//   mem_ready at edge N+1+W -> core_done high in the cycle after that edge.
//   Minimum is 2 cycles from req to done. A new req is accepted the cycle after DONE/ERR.
//  core_req while busy: ignored, not queued.
//  Stores, with k = addr[1:0]:
//   SB: wstrb = 4'b0001<<k,  wdata = {4{b}}
//   SH: wstrb = 4'b0011<<k,  wdata = {2{h}}
//   SW: wstrb = 4'b1111,     wdata = word
//  Loads: byte lane k / half lane k[1] of mem_rdata.
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//   core_rdata updates only on a successful load; stores and errors leave it unchanged.
// TESTING
//  LW 0x100, mem_ready on 1st valid cycle, rdata=0xDEADBEEF:
//    core_done 2 cycles after req; core_rdata=0xDEADBEEF.
//  LB 0x103, rdata=0x80112233 -> core_rdata=0xFFFFFF80.
//  LBU same access -> core_rdata=0x00000080.
//  SH 0x202 wdata=0x0000ABCD -> mem_addr=0x200, wstrb=4'b1100,
//    mem_wdata=0xABCDABCD, mem_we=1.
//  LW 0x102 -> core_error pulse 1 cycle after req, mem_valid never asserted.
//  TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high exactly 4 cycles, then core_error.
//    Repeat with mem_ready=1 on the 4th cycle -> core_done, no error.
//  Reset asserted during REQ wait -> next cycle all outputs 0, state IDLE;
//    a following LW completes normally.

Source files
------------

// File: rtl/lsu_bus_bridge_if.sv
// Memory-side ready/valid bus between the load/store bridge (master) and memory (slave).
interface lsu_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: turns one RV32I load/store from the core into a ready/valid
// bus access with byte strobes, lane steering, load extension, errors and timeout.
module lsu_bus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_done,
  output logic                  core_error,
  output logic                  core_busy,
  lsu_bus_bridge_if.master      bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            wstrb;
    logic [31:0]           wdata;
  } req_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  req_t                 req_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 bad, illegal, misalign, timeout;
  logic [3:0]           strb_d;
  logic [31:0]          wdata_d, load_val;
  logic [1:0]           k_d, k_q;
  logic [7:0]           lane_b;
  logic [15:0]          lane_h;

  // Decode of the incoming request; only meaningful in IDLE when core_req is high.
  always_comb begin
    k_d      = core_addr[1:0];
    illegal  = core_we ? (core_funct3[2] || core_funct3 == 3'b011)
                       : (core_funct3 == 3'b011 || core_funct3[2:1] == 2'b11);
    misalign = (core_funct3[1:0] == 2'b01 && k_d[0]) ||
               (core_funct3[1:0] == 2'b10 && k_d != 2'b00);
    bad      = illegal || misalign;
    case (core_funct3[1:0])
      2'b00:   begin strb_d = 4'b0001 << k_d; wdata_d = {4{core_wdata[7:0]}};  end
      2'b01:   begin strb_d = 4'b0011 << k_d; wdata_d = {2{core_wdata[15:0]}}; end
      default: begin strb_d = 4'b1111;        wdata_d = core_wdata;            end
    endcase
    if (!core_we) strb_d = 4'b0000;
  end

  // Load lane select and extension from the latched access.
  always_comb begin
    k_q    = req_q.addr[1:0];
    lane_b = bus.mem_rdata[8*k_q +: 8];
    lane_h = k_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (req_q.funct3)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'b0, lane_b};
      3'b101:  load_val = {16'b0, lane_h};
      default: load_val = bus.mem_rdata;
    endcase
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_req) state_nxt = bad ? ERR : REQ;
      REQ:     if (bus.mem_ready) state_nxt = DONE;
               else if (timeout)  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_done      = (state == DONE);
    core_error     = (state == ERR);
    core_busy      = (state != IDLE);
    bus.mem_valid  = (state == REQ);
    // Bus fields are forced to zero outside REQ so an idle bridge drives a quiet bus.
    bus.mem_we     = bus.mem_valid && req_q.we;
    bus.mem_addr   = bus.mem_valid ? {req_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    bus.mem_wstrb  = bus.mem_valid ? req_q.wstrb : 4'b0000;
    bus.mem_wdata  = bus.mem_valid ? req_q.wdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      cnt        <= '0;
      core_rdata <= 32'h0;
    end else begin
      if (state == IDLE && core_req)
        req_q <= '{we: core_we, funct3: core_funct3, addr: core_addr,
                   wstrb: strb_d, wdata: wdata_d};
      cnt <= (state == REQ) ? cnt + 1'b1 : '0;
      if (state == REQ && bus.mem_ready && !req_q.we)
        core_rdata <= load_val;
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: loads, stores, decode errors, timeout and reset.
module tb_lsu_bus_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_done, core_error, core_busy;
  int          tests_run = 0, tests_failed = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_bus_bridge_if #(.ADDR_WIDTH(32)) bus ();

  lsu_bus_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_funct3(core_funct3), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_done(core_done), .core_error(core_error),
    .core_busy(core_busy), .bus(bus)
  );

  // Present a request for one edge; returns at the negedge after it was sampled.
  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd; core_req = 1'b1;
    @(negedge clk);
    core_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({core_done, core_error, core_busy, core_rdata} !== 35'h0) begin
      tests_failed++; $display("FAIL reset_core: got %h want 0", {core_done, core_error, core_busy, core_rdata});
    end
    tests_run++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== 70'h0) begin
      tests_failed++; $display("FAIL reset_bus: got %h want 0", {bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw;
    start(1'b0, 3'b010, 32'h100, 32'h0);
    tests_run++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, core_done} !== {1'b1, 1'b0, 32'h100, 4'b0000, 1'b0}) begin
      tests_failed++; $display("FAIL lw_req: got v=%b we=%b a=%h s=%b d=%b want v=1 we=0 a=100 s=0000 d=0",
        bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, core_done);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    exp_rdata = 32'hDEADBEEF;
    tests_run++;
    if ({core_done, core_error, bus.mem_valid, core_rdata} !== {1'b1, 1'b0, 1'b0, exp_rdata}) begin
      tests_failed++; $display("FAIL lw_done: got d=%b e=%b v=%b r=%h want d=1 e=0 v=0 r=%h",
        core_done, core_error, bus.mem_valid, core_rdata, exp_rdata);
    end
    @(negedge clk);
    tests_run++;
    if ({core_done, core_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL lw_idle: got d=%b b=%b want 0 0", core_done, core_busy);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3[7]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
    logic [31:0] adr[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
    logic [31:0] rd[7]  = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233,
                            32'h0000007F, 32'h12348001, 32'h0000FF00};
    logic [31:0] ex[7]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011,
                            32'h0000007F, 32'hFFFF8001, 32'h000000FF};
    for (int i = 0; i < 7; i++) begin
      start(1'b0, f3[i], adr[i], 32'h0);
      bus.mem_ready = 1'b1; bus.mem_rdata = rd[i];
      @(negedge clk);
      bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
      exp_rdata = ex[i];
      tests_run++;
      if ({core_done, core_rdata} !== {1'b1, exp_rdata}) begin
        tests_failed++; $display("FAIL load_ext[%0d]: got d=%b r=%h want d=1 r=%h", i, core_done, core_rdata, exp_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store;
    logic [2:0]  f3[5]  = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
    logic [31:0] adr[5] = '{32'h202, 32'h201, 32'h203, 32'h204, 32'h100};
    logic [31:0] wd[5]  = '{32'h0000ABCD, 32'h12345677, 32'hFFFFFF5A, 32'hCAFEF00D, 32'h99991234};
    logic [31:0] ea[5]  = '{32'h200, 32'h200, 32'h200, 32'h204, 32'h100};
    logic [3:0]  es[5]  = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
    logic [31:0] ew[5]  = '{32'hABCDABCD, 32'h77777777, 32'h5A5A5A5A, 32'hCAFEF00D, 32'h12341234};
    for (int i = 0; i < 5; i++) begin
      start(1'b1, f3[i], adr[i], wd[i]);
      tests_run++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, 1'b1, ea[i], es[i], ew[i]}) begin
        tests_failed++; $display("FAIL store[%0d]: got v=%b we=%b a=%h s=%b w=%h want v=1 we=1 a=%h s=%b w=%h",
          i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, ea[i], es[i], ew[i]);
      end
      // A request arriving while busy must neither disturb the bus nor be queued.
      core_req = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h3F0;
      @(negedge clk);
      core_req = 1'b0;
      tests_run++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb} !== {1'b1, 1'b1, ea[i], es[i]}) begin
        tests_failed++; $display("FAIL store_hold[%0d]: got v=%b we=%b a=%h s=%b want v=1 we=1 a=%h s=%b",
          i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, ea[i], es[i]);
      end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13579BDF;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      tests_run++;
      if ({core_done, core_error, core_rdata} !== {1'b1, 1'b0, exp_rdata}) begin
        tests_failed++; $display("FAIL store_done[%0d]: got d=%b e=%b r=%h want d=1 e=0 r=%h",
          i, core_done, core_error, core_rdata, exp_rdata);
      end
      @(negedge clk);
      tests_run++;
      if ({core_busy, bus.mem_valid} !== 2'b00) begin
        tests_failed++; $display("FAIL store_noqueue[%0d]: got b=%b v=%b want 0 0", i, core_busy, bus.mem_valid);
      end
    end
  endtask

  task automatic test_decode_err;
    logic        we[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [2:0]  f3[10]  = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111,
                             3'b001, 3'b010, 3'b100, 3'b011};
    logic [31:0] adr[10] = '{32'h102, 32'h101, 32'h101, 32'h100, 32'h100, 32'h100,
                             32'h203, 32'h202, 32'h100, 32'h100};
    for (int i = 0; i < 10; i++) begin
      start(we[i], f3[i], adr[i], 32'h11111111);
      tests_run++;
      if ({core_error, core_done, bus.mem_valid, core_busy} !== 4'b1001) begin
        tests_failed++; $display("FAIL decode_err[%0d]: got e=%b d=%b v=%b b=%b want 1 0 0 1",
          i, core_error, core_done, bus.mem_valid, core_busy);
      end
      @(negedge clk);
      tests_run++;
      if ({core_error, bus.mem_valid, core_busy, core_rdata} !== {3'b000, exp_rdata}) begin
        tests_failed++; $display("FAIL decode_after[%0d]: got e=%b v=%b b=%b r=%h want 0 0 0 r=%h",
          i, core_error, bus.mem_valid, core_busy, core_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_timeout;
    int  nvalid = 0;
    bit  saw_err = 0;
    start(1'b0, 3'b010, 32'h300, 32'h0);
    for (int i = 0; i < 10 && !saw_err; i++) begin
      if (bus.mem_valid) nvalid++;
      if (core_error) saw_err = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (nvalid != 4 || !saw_err) begin
      tests_failed++; $display("FAIL timeout: got valid_cycles=%0d err=%0d want 4 1", nvalid, saw_err);
    end
    @(negedge clk);
    tests_run++;
    if ({core_error, core_busy, core_rdata} !== {2'b00, exp_rdata}) begin
      tests_failed++; $display("FAIL timeout_after: got e=%b b=%b r=%h want 0 0 r=%h", core_error, core_busy, core_rdata, exp_rdata);
    end
    // Ready on the last allowed cycle must win over the timeout.
    start(1'b0, 3'b010, 32'h304, 32'h0);
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.mem_valid, core_error} !== 2'b10) begin
      tests_failed++; $display("FAIL timeout_edge_valid: got v=%b e=%b want 1 0", bus.mem_valid, core_error);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    exp_rdata = 32'h55AA55AA;
    tests_run++;
    if ({core_done, core_error, core_rdata} !== {2'b10, exp_rdata}) begin
      tests_failed++; $display("FAIL timeout_edge_done: got d=%b e=%b r=%h want 1 0 r=%h", core_done, core_error, core_rdata, exp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    start(1'b0, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_rdata = 32'h0;
    tests_run++;
    if ({core_done, core_error, core_busy, core_rdata, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== 105'h0) begin
      tests_failed++; $display("FAIL reset_mid: got d=%b e=%b b=%b r=%h v=%b a=%h want all 0",
        core_done, core_error, core_busy, core_rdata, bus.mem_valid, bus.mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({core_done, core_error, core_busy} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_mid_quiet: got d=%b e=%b b=%b want 0 0 0", core_done, core_error, core_busy);
    end
    start(1'b0, 3'b010, 32'h404, 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    exp_rdata = 32'h0BADF00D;
    tests_run++;
    if ({core_done, core_rdata} !== {1'b1, exp_rdata}) begin
      tests_failed++; $display("FAIL reset_mid_lw: got d=%b r=%h want d=1 r=%h", core_done, core_rdata, exp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
    core_addr = 32'h0; core_wdata = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    test_reset;
    test_lw;
    test_load_ext;
    test_store;
    test_decode_err;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
